// File: rtl/hazard_pkg.sv
// Shared definitions for the forwarding/stall unit.
// Each tag entry is packed as {v, rd[REG_ADDR_W-1:0], ld}, with ld at the LSB.
// The positions of v and rd depend on the register address width, so they
// are provided as functions of that width.
package hazard_pkg;

  localparam int TAG_LD      = 0;
  localparam int TAG_RD_LO   = 1;
  localparam int SEL_REGFILE = 0;

  localparam logic [1:0] IMM_OPCODE_DEF = 2'b01;
  localparam int         REG_ADDR_W_DEF = 4;

  // Bit position of the valid flag within one tag entry.
  function automatic int tag_v_bit(input int addr_w);
    return addr_w + 1;
  endfunction

  // Width of one tag entry: {v, rd, ld}.
  function automatic int tag_w(input int addr_w);
    return addr_w + 2;
  endfunction

  localparam int TAG_V = tag_v_bit(REG_ADDR_W_DEF);

  // The immediate code sits just past the deepest forwarding stage.
  function automatic int sel_imm(input int fwd_depth);
    return fwd_depth + 1;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand tag matcher.
// Finds the youngest valid in-flight tag whose rd equals rs and turns it into
// a forwarding select. A load that is still too young to forward sets pending
// and leaves the select on the register file; the older stages are not
// consulted in that case, because their value would be stale.
// Ports:
//   rs      - operand source register
//   tags    - flattened tag chain, stage k at bits [(k-1)*TAG_W +: TAG_W]
//   sel     - 0 = register file, k = forward from stage k
//   pending - youngest match is a load that cannot be forwarded yet
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_DELAY = 1,
  parameter int SEL_W      = $clog2(FWD_DEPTH + 2)
) (
  input  logic [REG_ADDR_W-1:0]                   rs,
  input  logic [FWD_DEPTH*tag_w(REG_ADDR_W)-1:0]  tags,
  output logic [SEL_W-1:0]                        sel,
  output logic                                    pending
);

  localparam int TW    = tag_w(REG_ADDR_W);
  localparam int V_BIT = tag_v_bit(REG_ADDR_W);

  logic [FWD_DEPTH:1] hit;
  logic [FWD_DEPTH:1] is_ld;

  genvar k;
  generate
    for (k = 1; k <= FWD_DEPTH; k++) begin : g_cmp
      assign hit[k]   = tags[(k-1)*TW + V_BIT] &&
                        (tags[(k-1)*TW + TAG_RD_LO +: REG_ADDR_W] == rs);
      assign is_ld[k] = tags[(k-1)*TW + TAG_LD];
    end
  endgenerate

  // Walk from oldest to youngest so the youngest hit is the one that sticks.
  always_comb begin
    sel     = SEL_W'(SEL_REGFILE);
    pending = 1'b0;
    for (int i = FWD_DEPTH; i >= 1; i--) begin
      if (hit[i]) begin
        if (is_ld[i] && (i <= LOAD_DELAY)) begin
          pending = 1'b1;
          sel     = SEL_W'(SEL_REGFILE);
        end else begin
          pending = 1'b0;
          sel     = SEL_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_unit_pipe.sv
// Forwarding and load-use stall unit beside the decode stage.
// Tracks destination tags of in-flight instructions in a FWD_DEPTH-deep
// shift chain and produces the ALU operand mux selects and a decode stall.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   id_valid, id_instr  - decode slot valid and instruction (top 2 bits used)
//   id_rs_a/b, id_uses_a/b - operand sources and whether they are read
//   id_rd, id_writes, id_is_load - destination info of the decode instruction
//   flush               - kill the decode instruction
//   stall               - hold fetch/decode this cycle
//   muxA_sel, muxB_sel  - operand selects (B adds FWD_DEPTH+1 = immediate)
//   stall_count         - saturating count of stall cycles
module hazard_unit_pipe
  import hazard_pkg::*;
#(
  parameter int         REG_ADDR_W = 4,
  parameter int         INSTR_W    = 24,
  parameter int         FWD_DEPTH  = 2,
  parameter int         LOAD_DELAY = 1,
  parameter logic [1:0] IMM_OPCODE = IMM_OPCODE_DEF,
  parameter int         CNT_W      = 16,
  localparam int        SEL_W      = $clog2(FWD_DEPTH + 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [INSTR_W-1:0]    id_instr,
  input  logic [REG_ADDR_W-1:0] id_rs_a,
  input  logic [REG_ADDR_W-1:0] id_rs_b,
  input  logic                  id_uses_a,
  input  logic                  id_uses_b,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_writes,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic                  stall,
  output logic [SEL_W-1:0]      muxA_sel,
  output logic [SEL_W-1:0]      muxB_sel,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int TW = tag_w(REG_ADDR_W);

  logic [FWD_DEPTH*TW-1:0] tag_chain_q;
  logic [SEL_W-1:0]        sel_a;
  logic [SEL_W-1:0]        sel_b;
  logic                    pending_a;
  logic                    pending_b;
  logic                    imm;
  logic                    instr_unused;

  // Only the opcode bits matter here.
  assign instr_unused = ^id_instr[INSTR_W-3:0];

  hazard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_DEPTH  (FWD_DEPTH),
    .LOAD_DELAY (LOAD_DELAY),
    .SEL_W      (SEL_W)
  ) u_match_a (
    .rs      (id_rs_a),
    .tags    (tag_chain_q),
    .sel     (sel_a),
    .pending (pending_a)
  );

  hazard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_DEPTH  (FWD_DEPTH),
    .LOAD_DELAY (LOAD_DELAY),
    .SEL_W      (SEL_W)
  ) u_match_b (
    .rs      (id_rs_b),
    .tags    (tag_chain_q),
    .sel     (sel_b),
    .pending (pending_b)
  );

  assign imm = (id_instr[INSTR_W-1 -: 2] == IMM_OPCODE);

  // The immediate code wins for B even when the instruction does not read rs_b.
  assign muxA_sel = sel_a;
  assign muxB_sel = imm ? SEL_W'(sel_imm(FWD_DEPTH)) : sel_b;

  assign stall = id_valid & ~flush &
                 ((id_uses_a & pending_a) | (id_uses_b & ~imm & pending_b));

  // Stage 1 takes a bubble on flush or stall; older stages always advance so
  // the instruction that caused the stall drains toward a forwardable stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_chain_q <= '0;
    end else begin
      if (flush || stall) begin
        tag_chain_q[TW-1:0] <= '0;
      end else begin
        tag_chain_q[TW-1:0] <= {id_valid & id_writes, id_rd, id_is_load};
      end
      for (int k = 1; k < FWD_DEPTH; k++) begin
        tag_chain_q[k*TW +: TW] <= tag_chain_q[(k-1)*TW +: TW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule
